// File: rtl/imem_loader.sv
// imem_loader: assembles a framed byte stream into 16-bit words for a 16-entry instruction memory, holding the CPU in reset while loading.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte and the error flag.
module imem_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHK, FIN, DONE} state_e;
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d, addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [7:0] hi_q, hi_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic rdy_q, rdy_d, wr_en_q, wr_en_d, hold_q, hold_d, done_q, done_d;
    logic xfer, last_word, bad;
    assign xfer = in_valid && rdy_q;
    // COUNT of 0 means 16 words, so 0 - 1 wraps to 15 and still marks the last word
    assign last_word = addr_q == cnt_q - 4'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e LO_EXIT = CHK;
    logic [7:0] chk_q, chk_d;
    logic err_q, err_d;
    // XOR over COUNT, data and CHK bytes is zero for a good frame
    assign bad = chk_q != 8'h00;
    always_comb begin
        chk_d = chk_q;
        err_d = err_q;
        if (start && (state_q == IDLE || state_q == DONE)) err_d = 1'b0;
        else if (state_q == FIN) err_d = bad;
        if (xfer) chk_d = (state_q == COUNT) ? in_byte : chk_q ^ in_byte;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= 8'h00;
            err_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end
    assign error = err_q;
`else
    localparam state_e LO_EXIT = FIN;
    assign bad = 1'b0;
    assign error = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        hi_d = hi_q;
        wr_en_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d = hold_q;
        done_d = done_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = COUNT;
                hold_d = 1'b1;
                done_d = 1'b0;
            end
            COUNT: if (xfer) begin
                state_d = HI;
                cnt_d = in_byte[3:0];
                addr_d = 4'd0;
            end
            HI: if (xfer) begin
                state_d = LO;
                hi_d = in_byte;
            end
            LO: if (xfer) begin
                state_d = last_word ? LO_EXIT : HI;
                wr_en_d = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = {hi_q, in_byte};
                addr_d = addr_q + 4'd1;
            end
            CHK: if (xfer) state_d = FIN;
            FIN: begin
                state_d = DONE;
                done_d = 1'b1;
                hold_d = bad;
            end
            default: state_d = IDLE;
        endcase
    end
    assign rdy_d = state_d inside {COUNT, HI, LO, CHK};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= 4'd0;
            addr_q <= 4'd0;
            hi_q <= 8'h00;
            rdy_q <= 1'b0;
            wr_en_q <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 16'h0000;
            hold_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            hi_q <= hi_d;
            rdy_q <= rdy_d;
            wr_en_q <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q <= hold_d;
            done_q <= done_d;
        end
    end
    assign in_ready = rdy_q;
    assign wr_en = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cpu_hold = hold_q;
    assign done = done_q;
endmodule
